ring_fifo: RTL and testbench
============================

RING_FIFO -- requirements
Module: ring_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, ≥1.
REQ-002 Parameter DEPTH, default 16: storage words, ≥2; not required to be a power of two.
REQ-003 Parameter AFULL_LEVEL, default DEPTH-2: almost_full threshold.
REQ-004 Parameter AEMPTY_LEVEL, default 2: almost_empty threshold.
REQ-005 Parameter FWFT, default 0: 0 = registered read, 1 = first-word-fall-through.
REQ-006 Port clock, input, 1: single clock; all logic on rising edge.
REQ-007 Port resetn, input, 1: reset, asynchronous and active-low.
REQ-008 Port push, input, 1: write request.
REQ-009 Port data_in, input, WIDTH: write word.
REQ-010 Port pop, input, 1: read request.
REQ-011 Port flush, input, 1: synchronous empty command.
REQ-012 Port clear_err, input, 1: clears sticky error flags.
REQ-013 Port data_out, output, WIDTH: read word.
REQ-014 Port data_valid, output, 1: data_out qualifier.
REQ-015 Port full, empty, almost_full, almost_empty, output, 1 each: status.
REQ-016 Port level, output, $clog2(DEPTH+1): current occupancy.
REQ-017 Port overflow, underflow, output, 1 each: sticky error flags.

Function
REQ-018 Storage SHALL be a circular buffer with read/write pointers in 0..DEPTH-1, wrapping DEPTH-1 -> 0; no data shifting.
REQ-019 full = (level == DEPTH); empty = (level == 0); almost_full = (level >= AFULL_LEVEL); almost_empty = (level <= AEMPTY_LEVEL); all decoded from registered level.
REQ-020 Pop accepted = pop && !empty; push accepted = push && (!full || pop accepted).
REQ-021 Push and pop both accepted in one cycle: level unchanged, both pointers advance; legal when full (pass-through slot).
REQ-022 Push and pop when empty: push accepted, pop rejected, underflow set.
REQ-023 Push rejected (full, no accepted pop): data dropped, overflow set next edge.
REQ-024 Pop rejected when empty: underflow set next edge.
REQ-025 overflow/underflow SHALL stay set until clear_err; clear_err and a new error in the same cycle leaves the flag set.
REQ-026 FWFT=0: accepted pop loads head word into data_out at the next edge; data_valid high for exactly that one cycle; data_out holds its last value otherwise.
REQ-027 FWFT=1: data_out = word at read pointer whenever !empty; data_valid = !empty; pop acknowledges and advances.
REQ-028 Write-to-read latency: a word pushed into an empty FIFO is poppable the next cycle (FWFT=1: visible on data_out the next cycle).
REQ-029 flush SHALL take priority over push/pop that cycle: pointers and level zeroed, data_valid low; error flags and data_out unchanged.
REQ-030 level arithmetic SHALL never wrap; it saturates by construction at 0 and DEPTH.

Reset
REQ-031 On resetn low, immediately: pointers 0, level 0, empty 1, almost_empty 1, full 0, almost_full 0 (1 if AFULL_LEVEL==0), overflow 0, underflow 0, data_valid 0, data_out 0.
REQ-032 Reset mid-operation discards contents; storage array itself need not be reset.

Structure
REQ-033 Package buff_uart_pkg SHALL hold the level-width helper function and the FWFT mode enum constants.
REQ-034 Sub-module ring_fifo_ptr (DEPTH-wrapping pointer with increment enable and synchronous clear) SHALL be instantiated twice.
REQ-035 Elaboration SHALL fail if AFULL_LEVEL > DEPTH or AEMPTY_LEVEL >= DEPTH.

Verification (WIDTH=8, DEPTH=4)
REQ-036 Push 0x11,0x22,0x33,0x44 -> full=1 after 4th edge, level=4; pop x4 (FWFT=0) -> data_out 0x11..0x44, each with one-cycle data_valid.
REQ-037 Full, push 0x55 alone -> overflow=1, level=4; then pops yield 0x11..0x44 only; clear_err -> overflow=0.
REQ-038 Full, push 0x66 + pop together -> data_out 0x11, level=4, no overflow; after 5 further pops, 0x66 is fourth word out then underflow=1.
REQ-039 Pointer wrap: 10 cycles alternating push i / pop -> output sequence equals input, level toggles 1/0.
REQ-040 Level 3, flush + push 0x77 -> next cycle level=0, empty=1; resetn asserted mid-push -> all outputs at REQ-031 values within the same cycle.
REQ-041 FWFT=1: push 0xA5 into empty -> next cycle data_out=0xA5, data_valid=1 without pop.

Source files
------------

// File: rtl/buff_uart_pkg.sv
// buff_uart_pkg: shared FIFO mode constants and occupancy-width helper.
package buff_uart_pkg;
    typedef enum int {FWFT_REG = 0, FWFT_SHOW = 1} fwft_mode_e;

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/ring_fifo_ptr.sv
// ring_fifo_ptr: circular index 0..DEPTH-1 with increment enable and synchronous clear.
module ring_fifo_ptr #(
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     clear,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);
    localparam int PW = $clog2(DEPTH);

    always_ff @(posedge clock or negedge resetn)
        if (!resetn)
            ptr <= '0;
        else if (clear)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/ring_fifo.sv
// ring_fifo: circular-buffer FIFO with level status, sticky errors, flush and
// selectable registered or first-word-fall-through read.
module ring_fifo
    import buff_uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int AFULL_LEVEL  = DEPTH - 2,
    parameter int AEMPTY_LEVEL = 2,
    parameter int FWFT         = 0
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      push,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      pop,
    input  logic                      flush,
    input  logic                      clear_err,
    output logic [WIDTH-1:0]          data_out,
    output logic                      data_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      overflow,
    output logic                      underflow
);
    localparam int LW = level_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    if (AFULL_LEVEL > DEPTH || AEMPTY_LEVEL >= DEPTH) begin : g_bad_thresholds
        $error("ring_fifo: almost_full/almost_empty threshold out of range");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic             pop_ok, push_ok;

    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LW'(AFULL_LEVEL));
    assign almost_empty = (level <= LW'(AEMPTY_LEVEL));
    assign pop_ok       = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign push_ok      = push && (!full || pop_ok);

    ring_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clock(clock), .resetn(resetn), .clear(flush), .inc(push_ok && !flush), .ptr(wptr)
    );
    ring_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clock(clock), .resetn(resetn), .clear(flush), .inc(pop_ok && !flush), .ptr(rptr)
    );

    always_ff @(posedge clock)
        if (push_ok && !flush)
            mem[wptr] <= data_in;

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            level     <= flush ? '0 : level + LW'(push_ok) - LW'(pop_ok);
            overflow  <= (overflow && !clear_err) || (push && !push_ok && !flush);
            underflow <= (underflow && !clear_err) || (pop && empty && !flush);
        end

    if (FWFT == FWFT_SHOW) begin : g_fwft
        assign data_out   = empty ? '0 : mem[rptr];
        assign data_valid = !empty;
    end else begin : g_reg
        always_ff @(posedge clock or negedge resetn)
            if (!resetn) begin
                data_out   <= '0;
                data_valid <= 1'b0;
            end else begin
                data_valid <= pop_ok && !flush;
                if (pop_ok && !flush)
                    data_out <= mem[rptr];
            end
    end
endmodule

// File: tb/tb_ring_fifo.sv
// tb_ring_fifo: directed and randomized checks of ring_fifo (DEPTH=4) in both read modes
// against a queue-based reference model.
module tb_ring_fifo;
    localparam int D = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       push = 1'b0, pop = 1'b0, flush = 1'b0, clear_err = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] d0_out, d1_out;
    logic       d0_dv, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
    logic       d1_dv, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;
    logic [2:0] d0_lvl, d1_lvl;

    int checks = 0;
    int passed = 0;

    logic [7:0] q[$];
    logic       m_ovf = 1'b0, m_unf = 1'b0, m_dv = 1'b0;
    logic [7:0] m_out = '0;

    always #5 clock = ~clock;

    ring_fifo #(.WIDTH(8), .DEPTH(D), .FWFT(0)) dut0 (
        .clock(clock), .resetn(resetn), .push(push), .data_in(data_in), .pop(pop),
        .flush(flush), .clear_err(clear_err), .data_out(d0_out), .data_valid(d0_dv),
        .full(d0_full), .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
        .level(d0_lvl), .overflow(d0_ovf), .underflow(d0_unf)
    );

    ring_fifo #(.WIDTH(8), .DEPTH(D), .FWFT(1)) dut1 (
        .clock(clock), .resetn(resetn), .push(push), .data_in(data_in), .pop(pop),
        .flush(flush), .clear_err(clear_err), .data_out(d1_out), .data_valid(d1_dv),
        .full(d1_full), .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
        .level(d1_lvl), .overflow(d1_ovf), .underflow(d1_unf)
    );

    // drive one cycle, advance the reference model, return 1ns after the edge
    task automatic step(input logic pu, input logic [7:0] d, input logic po,
                        input logic fl, input logic ce);
        logic pop_acc, push_acc;
        push = pu; data_in = d; pop = po; flush = fl; clear_err = ce;
        if (fl) begin
            q.delete();
            m_dv  = 1'b0;
            m_ovf = m_ovf && !ce;
            m_unf = m_unf && !ce;
        end else begin
            pop_acc  = po && (q.size() > 0);
            push_acc = pu && ((q.size() < D) || pop_acc);
            m_ovf = (m_ovf && !ce) || (pu && !push_acc);
            m_unf = (m_unf && !ce) || (po && q.size() == 0);
            m_dv  = pop_acc;
            if (pop_acc) m_out = q.pop_front();
            if (push_acc) q.push_back(d);
        end
        @(posedge clock);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clear_err = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_dv = 1'b0; m_out = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks++; if (d0_empty !== 1'b1 || d0_ae !== 1'b1 || d0_full !== 1'b0 || d0_af !== 1'b0)
            $display("FAIL reset_status got e=%b ae=%b f=%b af=%b want 1 1 0 0", d0_empty, d0_ae, d0_full, d0_af);
        else passed++;
        checks++; if (d0_lvl !== 3'd0 || d0_ovf !== 1'b0 || d0_unf !== 1'b0 || d0_dv !== 1'b0 || d0_out !== 8'h00)
            $display("FAIL reset_outputs got lvl=%0d ovf=%b unf=%b dv=%b out=%h want 0 0 0 0 00", d0_lvl, d0_ovf, d0_unf, d0_dv, d0_out);
        else passed++;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp [4];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            step(1, exp[i], 0, 0, 0);
            checks++; if (d0_lvl !== 3'(i + 1))
                $display("FAIL fill_level got %0d want %0d", d0_lvl, i + 1);
            else passed++;
        end
        checks++; if (d0_full !== 1'b1 || d0_af !== 1'b1 || d0_empty !== 1'b0)
            $display("FAIL fill_full got f=%b af=%b e=%b want 1 1 0", d0_full, d0_af, d0_empty);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            checks++; if (d0_out !== exp[i] || d0_dv !== 1'b1)
                $display("FAIL drain_word%0d got out=%h dv=%b want %h 1", i, d0_out, d0_dv, exp[i]);
            else passed++;
        end
        step(0, 0, 0, 0, 0);
        checks++; if (d0_dv !== 1'b0 || d0_out !== 8'h44 || d0_empty !== 1'b1)
            $display("FAIL drain_idle got dv=%b out=%h e=%b want 0 44 1", d0_dv, d0_out, d0_empty);
        else passed++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp [4];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
        for (int i = 0; i < 4; i++) step(1, exp[i], 0, 0, 0);
        step(1, 8'h55, 0, 0, 0);
        checks++; if (d0_ovf !== 1'b1 || d0_lvl !== 3'd4)
            $display("FAIL overflow_set got ovf=%b lvl=%0d want 1 4", d0_ovf, d0_lvl);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            checks++; if (d0_out !== exp[i] || d0_ovf !== 1'b1)
                $display("FAIL overflow_drain%0d got out=%h ovf=%b want %h 1", i, d0_out, d0_ovf, exp[i]);
            else passed++;
        end
        checks++; if (d0_empty !== 1'b1)
            $display("FAIL overflow_dropped got empty=%b want 1", d0_empty);
        else passed++;
        step(0, 0, 0, 0, 1);
        checks++; if (d0_ovf !== 1'b0)
            $display("FAIL overflow_clear got %b want 0", d0_ovf);
        else passed++;
    endtask

    task automatic test_pass_through();
        logic [7:0] exp [4];
        exp[0] = 8'h22; exp[1] = 8'h33; exp[2] = 8'h44; exp[3] = 8'h66;
        step(1, 8'h11, 0, 0, 0); step(1, 8'h22, 0, 0, 0);
        step(1, 8'h33, 0, 0, 0); step(1, 8'h44, 0, 0, 0);
        step(1, 8'h66, 1, 0, 0);
        checks++; if (d0_out !== 8'h11 || d0_lvl !== 3'd4 || d0_ovf !== 1'b0 || d0_full !== 1'b1)
            $display("FAIL passthru got out=%h lvl=%0d ovf=%b full=%b want 11 4 0 1", d0_out, d0_lvl, d0_ovf, d0_full);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            checks++; if (d0_out !== exp[i] || d0_dv !== 1'b1)
                $display("FAIL passthru_pop%0d got out=%h dv=%b want %h 1", i, d0_out, d0_dv, exp[i]);
            else passed++;
        end
        step(0, 0, 1, 0, 0);
        checks++; if (d0_unf !== 1'b1 || d0_dv !== 1'b0 || d0_lvl !== 3'd0)
            $display("FAIL underflow got unf=%b dv=%b lvl=%0d want 1 0 0", d0_unf, d0_dv, d0_lvl);
        else passed++;
        step(1, 8'h99, 0, 0, 1);
        checks++; if (d0_unf !== 1'b0 || d0_lvl !== 3'd1)
            $display("FAIL underflow_clear got unf=%b lvl=%0d want 0 1", d0_unf, d0_lvl);
        else passed++;
        step(1, 8'h00, 0, 1, 0);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(8'hA0 + i), 0, 0, 0);
            checks++; if (d0_lvl !== 3'd1)
                $display("FAIL wrap_push%0d level got %0d want 1", i, d0_lvl);
            else passed++;
            step(0, 0, 1, 0, 0);
            checks++; if (d0_lvl !== 3'd0 || d0_out !== 8'(8'hA0 + i) || d0_dv !== 1'b1)
                $display("FAIL wrap_pop%0d got lvl=%0d out=%h dv=%b want 0 %h 1", i, d0_lvl, d0_out, d0_dv, 8'(8'hA0 + i));
            else passed++;
        end
    endtask

    task automatic test_flush();
        step(1, 8'h01, 0, 0, 0); step(1, 8'h02, 0, 0, 0); step(1, 8'h03, 0, 0, 0);
        checks++; if (d0_lvl !== 3'd3 || d0_af !== 1'b1 || d0_ae !== 1'b0)
            $display("FAIL flush_pre got lvl=%0d af=%b ae=%b want 3 1 0", d0_lvl, d0_af, d0_ae);
        else passed++;
        step(1, 8'h77, 1, 1, 0);
        checks++; if (d0_lvl !== 3'd0 || d0_empty !== 1'b1 || d0_dv !== 1'b0 || d0_out !== m_out)
            $display("FAIL flush got lvl=%0d e=%b dv=%b out=%h want 0 1 0 %h", d0_lvl, d0_empty, d0_dv, d0_out, m_out);
        else passed++;
        step(1, 8'h12, 0, 0, 0); step(1, 8'h34, 0, 0, 0);
        push = 1'b1; data_in = 8'h56;
        #3 resetn = 1'b0;
        #1;
        checks++; if (d0_lvl !== 3'd0 || d0_empty !== 1'b1 || d0_ae !== 1'b1 || d0_full !== 1'b0 ||
                      d0_af !== 1'b0 || d0_dv !== 1'b0 || d0_out !== 8'h00 || d0_ovf !== 1'b0 || d0_unf !== 1'b0)
            $display("FAIL midreset got lvl=%0d e=%b ae=%b f=%b af=%b dv=%b out=%h ovf=%b unf=%b want 0 1 1 0 0 0 00 0 0",
                     d0_lvl, d0_empty, d0_ae, d0_full, d0_af, d0_dv, d0_out, d0_ovf, d0_unf);
        else passed++;
        checks++; if (d1_dv !== 1'b0 || d1_lvl !== 3'd0)
            $display("FAIL midreset_fwft got dv=%b lvl=%0d want 0 0", d1_dv, d1_lvl);
        else passed++;
        push = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        model_reset();
    endtask

    task automatic test_fwft();
        step(1, 8'hA5, 0, 0, 0);
        checks++; if (d1_out !== 8'hA5 || d1_dv !== 1'b1 || d0_dv !== 1'b0)
            $display("FAIL fwft_show got out=%h dv=%b reg_dv=%b want a5 1 0", d1_out, d1_dv, d0_dv);
        else passed++;
        step(1, 8'h5A, 1, 0, 0);
        checks++; if (d1_out !== 8'h5A || d1_dv !== 1'b1)
            $display("FAIL fwft_advance got out=%h dv=%b want 5a 1", d1_out, d1_dv);
        else passed++;
        step(0, 0, 1, 0, 0);
        checks++; if (d1_dv !== 1'b0 || d1_empty !== 1'b1)
            $display("FAIL fwft_empty got dv=%b e=%b want 0 1", d1_dv, d1_empty);
        else passed++;
    endtask

    task automatic test_random();
        int n;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
            n = q.size();
            checks++; if (d0_lvl !== 3'(n) || d0_full !== (n == D) || d0_empty !== (n == 0) ||
                          d0_af !== (n >= D - 2) || d0_ae !== (n <= 2))
                $display("FAIL rand_status cyc%0d got lvl=%0d f=%b e=%b af=%b ae=%b want lvl=%0d", i, d0_lvl, d0_full, d0_empty, d0_af, d0_ae, n);
            else passed++;
            checks++; if (d0_ovf !== m_ovf || d0_unf !== m_unf)
                $display("FAIL rand_errors cyc%0d got ovf=%b unf=%b want %b %b", i, d0_ovf, d0_unf, m_ovf, m_unf);
            else passed++;
            checks++; if (d0_dv !== m_dv || d0_out !== m_out)
                $display("FAIL rand_read cyc%0d got dv=%b out=%h want %b %h", i, d0_dv, d0_out, m_dv, m_out);
            else passed++;
            checks++; if (d1_dv !== (n > 0) || (n > 0 && d1_out !== q[0]) || d1_lvl !== 3'(n))
                $display("FAIL rand_fwft cyc%0d got dv=%b out=%h lvl=%0d want dv=%b lvl=%0d", i, d1_dv, d1_out, d1_lvl, n > 0, n);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_pass_through();
        test_wrap();
        test_flush();
        test_fwft();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
